// File: rtl/spiral_to_raster_if.sv
// Stream bundle for spiral_to_raster: spiral-ordered input with frame dims, raster output.
// master drives the input stream and output ready; slave is the reorder block.
interface spiral_to_raster_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned R_WIDTH    = 3,
  parameter int unsigned C_WIDTH    = 3
) ();
  logic [R_WIDTH-1:0]    row;
  logic [C_WIDTH-1:0]    col;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_rdy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_rdy;
  logic                  data_out_last;

  modport master (
    output row, col, data_in, data_in_valid, data_out_rdy,
    input  data_in_rdy, data_out, data_out_valid, data_out_last
  );

  modport slave (
    input  row, col, data_in, data_in_valid, data_out_rdy,
    output data_in_rdy, data_out, data_out_valid, data_out_last
  );
endinterface

// File: rtl/spiral_to_raster.sv
// Buffers one clockwise-spiral-ordered frame, then replays it in raster order.
// Input is stalled while the frame drains; frames never overlap.
module spiral_to_raster #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned R_WIDTH    = 3,
  parameter int unsigned C_WIDTH    = 3
) (
  input logic                clk,
  input logic                rst,
  spiral_to_raster_if.slave  bus
);
  localparam int unsigned AW    = R_WIDTH + C_WIDTH;
  localparam int unsigned Depth = 1 << AW;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;
  typedef enum logic [1:0] {DirRight, DirDown, DirLeft, DirUp} dir_e;

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  logic [R_WIDTH-1:0]    nrow_q, nrow_d, top_q, top_d, bot_q, bot_d, r_q, r_d, rr_q, rr_d;
  logic [C_WIDTH-1:0]    ncol_q, ncol_d, lft_q, lft_d, rgt_q, rgt_d, c_q, c_d, rc_q, rc_d;
  logic [AW-1:0]         cnt_q, cnt_d, total_q, total_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dvalid_q, dvalid_d, dlast_q, dlast_d;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Current spiral position/bounds; in idle these come from the incoming dims.
  dir_e                  cur_dir, s_dir;
  logic [R_WIDTH-1:0]    cur_top, cur_bot, cur_r, s_top, s_bot, s_r;
  logic [C_WIDTH-1:0]    cur_lft, cur_rgt, cur_c, s_lft, s_rgt, s_c;

  logic                  in_rdy, in_fire, out_fire, load_out, last_rd, we;
  logic [AW-1:0]         frame_total;

  assign in_rdy      = !rst && (state_q != StDrain);
  assign in_fire     = bus.data_in_valid && in_rdy;
  assign out_fire    = dvalid_q && bus.data_out_rdy;
  assign frame_total = AW'(bus.row) * AW'(bus.col);
  assign last_rd     = (rr_q == nrow_q - 1'b1) && (rc_q == ncol_q - 1'b1);
  assign load_out    = (state_q == StDrain) && rd_pend_q && (!dvalid_q || bus.data_out_rdy);

  assign bus.data_in_rdy    = in_rdy;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = dvalid_q;
  assign bus.data_out_last  = dlast_q;

  always_comb begin
    if (state_q == StIdle) begin
      cur_dir = DirRight;
      cur_top = '0;
      cur_bot = bus.row - 1'b1;
      cur_lft = '0;
      cur_rgt = bus.col - 1'b1;
      cur_r   = '0;
      cur_c   = '0;
    end else begin
      cur_dir = dir_q;
      cur_top = top_q;
      cur_bot = bot_q;
      cur_lft = lft_q;
      cur_rgt = rgt_q;
      cur_r   = r_q;
      cur_c   = c_q;
    end
  end

  // One clockwise step; reaching a corner shrinks the bound just walked.
  always_comb begin
    s_dir = cur_dir;
    s_top = cur_top;
    s_bot = cur_bot;
    s_lft = cur_lft;
    s_rgt = cur_rgt;
    s_r   = cur_r;
    s_c   = cur_c;
    unique case (cur_dir)
      DirRight: begin
        if (cur_c == cur_rgt) begin
          s_top = cur_top + 1'b1;
          s_dir = DirDown;
          s_r   = cur_r + 1'b1;
        end else begin
          s_c = cur_c + 1'b1;
        end
      end
      DirDown: begin
        if (cur_r == cur_bot) begin
          s_rgt = cur_rgt - 1'b1;
          s_dir = DirLeft;
          s_c   = cur_c - 1'b1;
        end else begin
          s_r = cur_r + 1'b1;
        end
      end
      DirLeft: begin
        if (cur_c == cur_lft) begin
          s_bot = cur_bot - 1'b1;
          s_dir = DirUp;
          s_r   = cur_r - 1'b1;
        end else begin
          s_c = cur_c - 1'b1;
        end
      end
      DirUp: begin
        if (cur_r == cur_top) begin
          s_lft = cur_lft + 1'b1;
          s_dir = DirRight;
          s_c   = cur_c + 1'b1;
        end else begin
          s_r = cur_r - 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    nrow_d    = nrow_q;
    ncol_d    = ncol_q;
    top_d     = top_q;
    bot_d     = bot_q;
    lft_d     = lft_q;
    rgt_d     = rgt_q;
    r_d       = r_q;
    c_d       = c_q;
    rr_d      = rr_q;
    rc_d      = rc_q;
    cnt_d     = cnt_q;
    total_d   = total_q;
    rd_pend_d = rd_pend_q;
    dout_d    = dout_q;
    dvalid_d  = dvalid_q;
    dlast_d   = dlast_q;
    we        = 1'b0;

    unique case (state_q)
      StIdle, StLoad: begin
        rr_d      = '0;
        rc_d      = '0;
        rd_pend_d = 1'b1;
        if (in_fire && (state_q == StLoad || (bus.row != '0 && bus.col != '0))) begin
          we    = 1'b1;
          dir_d = s_dir;
          top_d = s_top;
          bot_d = s_bot;
          lft_d = s_lft;
          rgt_d = s_rgt;
          r_d   = s_r;
          c_d   = s_c;
          if (state_q == StIdle) begin
            nrow_d  = bus.row;
            ncol_d  = bus.col;
            total_d = frame_total;
            cnt_d   = AW'(1);
            state_d = (frame_total == AW'(1)) ? StDrain : StLoad;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 == total_q) state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (load_out) begin
          dout_d   = mem[{rr_q, rc_q}];
          dvalid_d = 1'b1;
          dlast_d  = last_rd;
          if (last_rd) begin
            rd_pend_d = 1'b0;
          end else if (rc_q == ncol_q - 1'b1) begin
            rc_d = '0;
            rr_d = rr_q + 1'b1;
          end else begin
            rc_d = rc_q + 1'b1;
          end
        end else if (out_fire) begin
          dvalid_d = 1'b0;
          dlast_d  = 1'b0;
        end
        if (out_fire && dlast_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[{cur_r, cur_c}] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dir_q     <= DirRight;
      nrow_q    <= '0;
      ncol_q    <= '0;
      top_q     <= '0;
      bot_q     <= '0;
      lft_q     <= '0;
      rgt_q     <= '0;
      r_q       <= '0;
      c_q       <= '0;
      rr_q      <= '0;
      rc_q      <= '0;
      cnt_q     <= '0;
      total_q   <= '0;
      rd_pend_q <= 1'b0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      dlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      nrow_q    <= nrow_d;
      ncol_q    <= ncol_d;
      top_q     <= top_d;
      bot_q     <= bot_d;
      lft_q     <= lft_d;
      rgt_q     <= rgt_d;
      r_q       <= r_d;
      c_q       <= c_d;
      rr_q      <= rr_d;
      rc_q      <= rc_d;
      cnt_q     <= cnt_d;
      total_q   <= total_d;
      rd_pend_q <= rd_pend_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      dlast_q   <= dlast_d;
    end
  end
endmodule

// File: tb/tb_spiral_to_raster.sv
// Bench for spiral_to_raster: a coordinate-list model predicts raster output and handshake
// behaviour every cycle; directed frames with literal expected sequences pin the model.
module tb_spiral_to_raster;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 3;

  typedef int iq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spiral_to_raster_if #(.DATA_WIDTH(DW), .R_WIDTH(RW), .C_WIDTH(CW)) bus ();

  spiral_to_raster #(.DATA_WIDTH(DW), .R_WIDTH(RW), .C_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raster indices of a nr x nc matrix in clockwise spiral order, peeled ring by ring.
  function automatic iq_t spiral_order(input int nr, input int nc);
    iq_t o;
    int t = 0, b = nr - 1, l = 0, rt = nc - 1;
    while (t <= b && l <= rt) begin
      for (int c = l; c <= rt; c++) o.push_back(t * nc + c);
      for (int r = t + 1; r <= b; r++) o.push_back(r * nc + rt);
      if (t < b) for (int c = rt - 1; c >= l; c--) o.push_back(b * nc + c);
      if (l < rt) for (int r = b - 1; r > t; r--) o.push_back(r * nc + l);
      t++; b--; l++; rt--;
    end
    return o;
  endfunction

  // Model state
  bit  m_loading = 0, m_draining = 0;
  int  m_age = 0, m_k = 0, m_nr = 0, m_nc = 0;
  iq_t m_ord;
  int  m_mem[64];
  int  m_q[$];
  int  got[$];
  bit  prev_stall = 0;
  int  prev_data = 0, prev_last = 0;
  bit  ev;

  always @(negedge clk) begin
    if (rst) begin
      chk(bus.data_in_rdy == 1'b0, "in_rdy_during_rst", bus.data_in_rdy, 0);
      m_loading  = 0;
      m_draining = 0;
      m_q.delete();
      prev_stall = 0;
    end else begin
      ev = m_draining && m_age >= 1;
      chk(bus.data_in_rdy == !m_draining, "in_rdy", bus.data_in_rdy, !m_draining);
      chk(bus.data_out_valid == ev, "out_valid", bus.data_out_valid, ev);
      if (bus.data_out_valid && ev) begin
        if (m_q.size() == 0) begin
          chk(1'b0, "out_extra", bus.data_out, -1);
        end else begin
          chk(bus.data_out == m_q[0], "out_data", bus.data_out, m_q[0]);
          chk(bus.data_out_last == (m_q.size() == 1), "out_last", bus.data_out_last,
              m_q.size() == 1);
        end
      end
      if (prev_stall) begin
        chk(bus.data_out == prev_data, "hold_data", bus.data_out, prev_data);
        chk(bus.data_out_last == prev_last, "hold_last", bus.data_out_last, prev_last);
      end
      prev_stall = bus.data_out_valid && !bus.data_out_rdy;
      prev_data  = int'(bus.data_out);
      prev_last  = int'(bus.data_out_last);
      if (bus.data_out_valid && bus.data_out_rdy) got.push_back(int'(bus.data_out));
      if (ev && bus.data_out_rdy && m_q.size() > 0) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_draining = 0;
      end
      if (m_draining) m_age++;
      if (bus.data_in_valid && bus.data_in_rdy) begin
        if (!m_loading && bus.row != '0 && bus.col != '0) begin
          m_nr      = int'(bus.row);
          m_nc      = int'(bus.col);
          m_ord     = spiral_order(m_nr, m_nc);
          m_k       = 0;
          m_loading = 1;
        end
        if (m_loading) begin
          m_mem[m_ord[m_k]] = int'(bus.data_in);
          m_k++;
          if (m_k == m_nr * m_nc) begin
            m_q.delete();
            for (int i = 0; i < m_k; i++) m_q.push_back(m_mem[i]);
            m_loading  = 0;
            m_draining = 1;
            m_age      = 0;
          end
        end
      end
    end
  end

  // Output ready: 0 = always, 1 = pattern 1,0,0 repeating, 2 = never.
  int bp_mode = 0;
  int bp_cnt  = 0;
  initial bus.data_out_rdy = 1'b1;
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      1:       bus.data_out_rdy = (bp_cnt % 3 == 0);
      2:       bus.data_out_rdy = 1'b0;
      default: bus.data_out_rdy = 1'b1;
    endcase
    bp_cnt++;
  end

  task automatic send(input int nr, input int nc, input iq_t v, input bit gaps);
    bit acc;
    int t;
    bus.row = RW'(nr);
    bus.col = CW'(nc);
    foreach (v[i]) begin
      if (gaps) begin
        bus.data_in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      bus.data_in       = DW'(v[i]);
      bus.data_in_valid = 1'b1;
      acc = 0;
      t   = 0;
      while (!acc && t < 100) begin
        @(negedge clk);
        acc = bus.data_in_rdy;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) chk(1'b0, "send_timeout", t, 100);
    end
    bus.data_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (m_draining && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) chk(1'b0, "drain_timeout", t, 500);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_got(input iq_t exp, input string name);
    chk(got.size() == exp.size(), {name, "_count"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) chk(got[i] == exp[i], name, got[i], exp[i]);
    end
    got.delete();
  endtask

  task automatic chk_reset_vals(input string tag, input bit exp_rdy);
    chk(bus.data_out_valid == 1'b0, {tag, "_valid"}, bus.data_out_valid, 0);
    chk(bus.data_out_last == 1'b0, {tag, "_last"}, bus.data_out_last, 0);
    chk(bus.data_out == '0, {tag, "_data"}, bus.data_out, 0);
    chk(bus.data_in_rdy == exp_rdy, {tag, "_in_rdy"}, bus.data_in_rdy, exp_rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  iq_t v, e;

  initial begin
    bus.row = '0;
    bus.col = '0;
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_hold", 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(bus.data_in_rdy == 1'b1, "in_rdy_after_rst", bus.data_in_rdy, 1);
    @(posedge clk);
    #1;

    // 3x3 with latency pin
    v = '{1, 2, 3, 6, 9, 8, 7, 4, 5};
    send(3, 3, v, 1'b0);
    @(negedge clk);
    chk(bus.data_out_valid == 1'b0, "lat_edge_n", bus.data_out_valid, 0);
    @(negedge clk);
    chk(bus.data_out_valid == 1'b1, "lat_edge_n1", bus.data_out_valid, 1);
    chk(bus.data_out == 8'd1, "lat_first_data", bus.data_out, 1);
    wait_idle();
    e = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    check_got(e, "f3x3");

    // 7x5: beat k carries the raster index of the k-th spiral position
    v = spiral_order(7, 5);
    chk(v.size() == 35, "order7x5_len", v.size(), 35);
    send(7, 5, v, 1'b0);
    wait_idle();
    e.delete();
    for (int i = 0; i < 35; i++) e.push_back(i);
    check_got(e, "f7x5");

    v = '{1, 2, 3, 4};
    send(1, 4, v, 1'b0);
    wait_idle();
    e = '{1, 2, 3, 4};
    check_got(e, "f1x4");

    v = '{1, 2, 3, 4};
    send(4, 1, v, 1'b0);
    wait_idle();
    check_got(e, "f4x1");

    v = '{170};
    send(1, 1, v, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk(bus.data_out == 8'hAA, "f1x1_data", bus.data_out, 170);
    chk(bus.data_out_last == 1'b1, "f1x1_last", bus.data_out_last, 1);
    wait_idle();
    e = '{170};
    check_got(e, "f1x1");

    // Backpressure on a 2x3 frame
    bp_mode = 1;
    v = '{1, 2, 3, 6, 5, 4};
    send(2, 3, v, 1'b0);
    wait_idle();
    bp_mode = 0;
    e = '{1, 2, 3, 4, 5, 6};
    check_got(e, "f2x3_bp");

    // Zero dimensions are discarded
    v = '{9, 9, 9};
    send(0, 3, v, 1'b0);
    v = '{7, 7};
    send(2, 0, v, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    e.delete();
    check_got(e, "zero_dims");

    // Input bubbles
    v = '{1, 2, 3, 6, 9, 8, 7, 4, 5};
    send(3, 3, v, 1'b1);
    wait_idle();
    e = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    check_got(e, "f3x3_gaps");

    // Reset mid-load, then a clean 2x2
    v = '{1, 2, 3, 6};
    send(3, 3, v, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_load", 1'b1);
    @(posedge clk);
    #1;
    v = '{1, 2, 4, 3};
    send(2, 2, v, 1'b0);
    wait_idle();
    e = '{1, 2, 3, 4};
    check_got(e, "f2x2_after_rst");

    // Reset mid-drain with output stalled
    bp_mode = 2;
    v = '{5, 6, 7, 8};
    send(1, 4, v, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bp_mode = 0;
    @(negedge clk);
    chk_reset_vals("rst_drain", 1'b1);
    repeat (3) @(posedge clk);
    #1;
    e.delete();
    check_got(e, "rst_drain_out");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spiral_to_raster.md
# spiral_to_raster

Inverse of the spiral reorder block. It accepts a row×col matrix streamed in clockwise spiral order: start at top-left, go right, down, left, up, and repeat inward. It buffers the whole frame, then emits the same elements in raster order (row-major, top-left first). It sits downstream of the spiral block, or consumes any spiral-ordered stream, and uses the same valid/rdy handshake on both sides.

## Interface
- DATA_WIDTH, 8, element width
- R_WIDTH, 3, row-count width; max rows 2^R_WIDTH-1
- C_WIDTH, 3, col-count width; max cols 2^C_WIDTH-1
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- row  input  R_WIDTH  frame row count, sampled on first accepted beat of a frame
- col  input  C_WIDTH  frame col count, sampled with row
- data_in  input  DATA_WIDTH  spiral-ordered element
- data_in_valid  input  1  data_in valid
- data_in_rdy  output  1  block accepts data_in this cycle
- data_out  output  DATA_WIDTH  raster-ordered element
- data_out_valid  output  1  data_out valid
- data_out_rdy  input  1  downstream accepts data_out
- data_out_last  output  1  high with the final raster element of a frame

## Operation
- Storage: 2^R_WIDTH × 2^C_WIDTH × DATA_WIDTH array, address = {r, c}.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - data_in_rdy=1.
  - On an accepted beat with row≠0 and col≠0: latch nrow=row, ncol=col.
  - Init boundaries top=0, bottom=nrow-1, left=0, right=ncol-1; r=c=0; dir=RIGHT.
  - Write the beat to (0,0) and apply the spiral step (below).
  - If nrow·ncol==1, go to DRAIN; else go to LOAD.
- IDLE with row==0 or col==0: the accepted beat is discarded; no frame starts; state stays IDLE.
- LOAD:
  - data_in_rdy=1; each accepted beat is written to (r,c), then the spiral step is applied.
  - The beat that makes the element count reach nrow·ncol moves the state to DRAIN.
  - row/col changes during LOAD are ignored.
- Spiral step, evaluated on the current position:
  - RIGHT: if c==right → top+1, dir DOWN, r+1; else c+1.
  - DOWN: if r==bottom → right-1, dir LEFT, c-1; else r+1.
  - LEFT: if c==left → bottom-1, dir UP, r-1; else c-1.
  - UP: if r==top → left+1, dir RIGHT, c+1; else r-1.
  - The step after the final element is don't-care.
- Element counter width: R_WIDTH+C_WIDTH bits; product nrow·ncol computed at full width, no truncation.
- DRAIN:
  - data_in_rdy=0.
  - Read pointer (rr,rc) walks rc 0..ncol-1 within rr 0..nrow-1.
  - Output register loads mem[rr][rc] whenever (!data_out_valid || data_out_rdy) and reads remain.
  - data_out_last is set with the element (nrow-1, ncol-1).
  - When the last element is accepted (valid&rdy&last), the state returns to IDLE.
- data_out and data_out_last hold stable while data_out_valid=1 and data_out_rdy=0.
- No overlap between frames: input is stalled for the whole DRAIN.

## Timing
- Reset values: data_in_rdy=0 while rst=1; data_out_valid=0, data_out_last=0, data_out=0; state IDLE; counters/pointers 0. data_in_rdy=1 the first cycle after rst deasserts.
- data_in_rdy is decoded from state (registered state, combinational decode).
- Input throughput: 1 element/cycle in IDLE/LOAD.
- Last input beat accepted at edge N → state DRAIN after N → first data_out_valid=1 after edge N+1 (2-cycle latency).
- Output throughput: 1 element/cycle with data_out_rdy held high.
- Last output accepted at edge M → data_in_rdy=1 after M.
- Input bubbles (data_in_valid=0) leave all LOAD state unchanged.
- Reset mid-LOAD or mid-DRAIN: partial frame discarded; all outputs return to reset values next cycle; memory contents don't-care.

## Test plan
- 3×3, spiral input 1,2,3,6,9,8,7,4,5, data_out_rdy=1 → output 1..9 in order; last only on 9; first valid 2 cycles after input 5 is accepted.
- 7×5 (row=7, col=5): feed the spiral ordering of raster values 0..34 → output 0..34; data_in_rdy=0 from the cycle after the 35th beat until 34 is accepted.
- Degenerate shapes: 1×4 input 1,2,3,4 → 1,2,3,4; 4×1 input 1,2,3,4 → 1,2,3,4; 1×1 input 0xAA → 0xAA with last=1.
- Backpressure: 2×3 frame, data_out_rdy toggles 1,0,0,1,… → every element held stable while stalled; sequence intact, no duplicates or drops.
- Dims and bubbles: row=0 with valid beats → no output, rdy stays 1. Random valid gaps during a 3×3 load → same result as the first scenario.
- Reset: rst pulsed after 4 beats of a 3×3 load → outputs at reset values; a following full 2×2 frame (1,2,4,3 in) → 1,2,3,4 out.
